// File: rtl/bcp_scheduler.sv
// bcp_scheduler: sequences one BCP round, round-robin applying check-unit implications
// Ports:
//   clock, reset (async, active-low), start          - control
//   init_assignment, init_free                        - initial variable state loaded at start
//   imp_valid, imp_vec, imp_pol                       - per-unit implication reports
//   unit_load, clause_enable                          - one-cycle pulses to the check units
//   grant                                             - one-hot unit whose implication is applied
//   assignment, free                                  - shared variable state driving the check units
//   imp_count, busy, done, conflict                   - round status
module bcp_scheduler #(
    parameter int var_num  = 8,
    parameter int unit_num = 4,
    parameter int size     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [var_num-1:0]          init_assignment,
    input  logic [var_num-1:0]          init_free,
    input  logic [unit_num-1:0]         imp_valid,
    input  logic [unit_num*var_num-1:0] imp_vec,
    input  logic [unit_num-1:0]         imp_pol,
    output logic                        unit_load,
    output logic                        clause_enable,
    output logic [unit_num-1:0]         grant,
    output logic [var_num-1:0]          assignment,
    output logic [var_num-1:0]          free,
    output logic [size-1:0]             imp_count,
    output logic                        busy,
    output logic                        done,
    output logic                        conflict
);
    localparam int PW = unit_num > 1 ? $clog2(unit_num) : 1;
    localparam int VW = var_num > 1 ? $clog2(var_num) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, WAIT, ARB, APPLY, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, sel_g_q, sel_g_d;
    logic [VW-1:0]       sel_v_q, sel_v_d;
    logic                sel_pol_q, sel_pol_d;
    logic [var_num-1:0]  assignment_q, assignment_d, free_q, free_d;
    logic [size-1:0]     imp_count_q, imp_count_d;
    logic [unit_num-1:0] grant_q, grant_d;
    logic                unit_load_q, unit_load_d, clause_enable_q, clause_enable_d;
    logic                busy_q, busy_d, done_q, done_d, conflict_q, conflict_d;

    logic [var_num-1:0]  vecs [unit_num];
    logic                found;
    logic [PW-1:0]       c, cand;
    logic [var_num-1:0]  hit;
    logic [VW-1:0]       tgt;

    for (genvar u = 0; u < unit_num; u++) begin : g_split
        assign vecs[u] = imp_vec[u*var_num +: var_num];
    end

    // Round-robin search starting at ptr, then lowest free literal of the winner.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        c     = '0;
        tgt   = '0;
        for (int k = 0; k < unit_num; k++) begin
            c = PW'((int'(ptr_q) + k) % unit_num);
            if (!found && imp_valid[c]) begin
                found = 1'b1;
                cand  = c;
            end
        end
        hit = vecs[cand] & free_q;
        for (int j = var_num - 1; j >= 0; j--)
            if (hit[j]) tgt = VW'(j);
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        sel_g_d         = sel_g_q;
        sel_v_d         = sel_v_q;
        sel_pol_d       = sel_pol_q;
        assignment_d    = assignment_q;
        free_d          = free_q;
        imp_count_d     = imp_count_q;
        busy_d          = busy_q;
        conflict_d      = conflict_q;
        unit_load_d     = 1'b0;
        clause_enable_d = 1'b0;
        grant_d         = '0;
        done_d          = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d      = LOAD;
                assignment_d = init_assignment;
                free_d       = init_free;
                imp_count_d  = '0;
                conflict_d   = 1'b0;
                busy_d       = 1'b1;
                unit_load_d  = 1'b1;
            end
            LOAD: begin
                state_d         = EVAL;
                clause_enable_d = 1'b1;
            end
            EVAL: state_d = WAIT;
            WAIT: state_d = ARB;
            ARB: begin
                if (!found || hit == '0) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    conflict_d = found;
                end else begin
                    state_d   = APPLY;
                    grant_d   = unit_num'(1) << cand;
                    sel_g_d   = cand;
                    sel_v_d   = tgt;
                    sel_pol_d = imp_pol[cand];
                end
            end
            APPLY: begin
                // Counters inside the check units persist, so only EVAL is re-pulsed.
                state_d               = EVAL;
                clause_enable_d       = 1'b1;
                assignment_d[sel_v_q] = sel_pol_q;
                free_d[sel_v_q]       = 1'b0;
                imp_count_d           = &imp_count_q ? imp_count_q : imp_count_q + size'(1);
                ptr_d                 = sel_g_q == PW'(unit_num - 1) ? '0 : sel_g_q + PW'(1);
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            sel_g_q         <= '0;
            sel_v_q         <= '0;
            sel_pol_q       <= 1'b0;
            assignment_q    <= '0;
            free_q          <= '0;
            imp_count_q     <= '0;
            grant_q         <= '0;
            unit_load_q     <= 1'b0;
            clause_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            conflict_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            sel_g_q         <= sel_g_d;
            sel_v_q         <= sel_v_d;
            sel_pol_q       <= sel_pol_d;
            assignment_q    <= assignment_d;
            free_q          <= free_d;
            imp_count_q     <= imp_count_d;
            grant_q         <= grant_d;
            unit_load_q     <= unit_load_d;
            clause_enable_q <= clause_enable_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            conflict_q      <= conflict_d;
        end
    end

    assign unit_load     = unit_load_q;
    assign clause_enable = clause_enable_q;
    assign grant         = grant_q;
    assign assignment    = assignment_q;
    assign free          = free_q;
    assign imp_count     = imp_count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign conflict      = conflict_q;
endmodule

// File: tb/tb_bcp_scheduler.sv
// tb_bcp_scheduler: randomized and directed rounds against a behavioural BCP model
module tb_bcp_scheduler;
    localparam int V = 8;
    localparam int U = 4;
    localparam int S = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [V-1:0]   init_assignment = '0;
    logic [V-1:0]   init_free = '0;
    logic [U-1:0]   imp_valid;
    logic [U*V-1:0] imp_vec;
    logic [U-1:0]   imp_pol;
    logic           unit_load, clause_enable, busy, done, conflict;
    logic [U-1:0]   grant;
    logic [V-1:0]   assignment, free;
    logic [S-1:0]   imp_count;

    // Emulated check units: mode 0 = valid while any own literal is free,
    // mode 1 = always valid, mode 2 = valid until granted once.
    logic [V-1:0]   u_vec [U];
    logic [1:0]     u_mode [U];
    logic [U-1:0]   u_en = '0;
    logic [U-1:0]   u_used = '0;
    logic [U-1:0]   u_pol = '0;

    int errors = 0;
    int checks = 0;
    int m_ptr = 0;
    int exp_grants [$];

    bcp_scheduler #(.var_num(V), .unit_num(U), .size(S)) dut (
        .clock(clock), .reset(reset), .start(start),
        .init_assignment(init_assignment), .init_free(init_free),
        .imp_valid(imp_valid), .imp_vec(imp_vec), .imp_pol(imp_pol),
        .unit_load(unit_load), .clause_enable(clause_enable), .grant(grant),
        .assignment(assignment), .free(free), .imp_count(imp_count),
        .busy(busy), .done(done), .conflict(conflict)
    );

    always #5 clock = ~clock;

    assign imp_pol = u_pol;

    always_comb begin
        imp_vec   = '0;
        imp_valid = '0;
        for (int i = 0; i < U; i++) begin
            imp_vec[i*V +: V] = u_vec[i];
            imp_valid[i] = u_en[i] && (u_mode[i] == 2'd1 || (u_mode[i] == 2'd0 && |(u_vec[i] & free))
                           || (u_mode[i] == 2'd2 && !u_used[i]));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit uvalid(input int i, input logic [V-1:0] f, input logic [U-1:0] used);
        return u_en[i] && (u_mode[i] == 2'd1 || (u_mode[i] == 2'd0 && (u_vec[i] & f) != 0)
               || (u_mode[i] == 2'd2 && !used[i]));
    endfunction

    task automatic model(input logic [V-1:0] ia, input logic [V-1:0] ifr, output logic [V-1:0] ea,
                         output logic [V-1:0] ef, output int n, output logic ec, output int np);
        logic [U-1:0] used = '0;
        int g, v;
        ea = ia; ef = ifr; n = 0; ec = 1'b0; np = m_ptr; v = 0;
        exp_grants.delete();
        while (1) begin
            g = -1;
            for (int k = 0; k < U; k++) begin
                int i;
                i = (np + k) % U;
                if (g < 0 && uvalid(i, ef, used)) g = i;
            end
            if (g < 0) break;
            if ((u_vec[g] & ef) == 0) begin
                ec = 1'b1;
                break;
            end
            for (int j = V - 1; j >= 0; j--) if (u_vec[g][j] && ef[j]) v = j;
            ea[v] = u_pol[g];
            ef[v] = 1'b0;
            n++;
            used[g] = 1'b1;
            exp_grants.push_back(1 << g);
            np = (g + 1) % U;
        end
    endtask

    // Caller is positioned at a negedge; returns at the negedge one cycle after done.
    task automatic run_round(input logic [V-1:0] ia, input logic [V-1:0] ifr, input bit poke_busy, input bit poke_done);
        logic [V-1:0] ea, ef;
        logic ec;
        int n, np, cyc, done_cyc, ul_cyc, ce_n;
        logic [U-1:0] got [$];
        model(ia, ifr, ea, ef, n, ec, np);
        u_used = '0;
        init_assignment = ia;
        init_free = ifr;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1; done_cyc = -1; ul_cyc = -1; ce_n = 0;
        while (cyc <= 200) begin
            if (poke_busy) start = (cyc == 3);
            if (cyc == 1) chk("busy_rise", busy, 1);
            if (unit_load && ul_cyc < 0) ul_cyc = cyc;
            if (clause_enable) ce_n++;
            if (grant != 0) begin
                got.push_back(grant);
                u_used = u_used | grant;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        start = poke_done;
        @(negedge clock);
        start = 1'b0;
        chk("busy_fall", busy, 0);
        chk("done_width", done, 0);
        chk("ul_idle", unit_load, 0);
        chk("done_cyc", done_cyc, 5 + 4 * n);
        chk("ul_cyc", ul_cyc, 1);
        chk("ce_count", ce_n, 1 + n);
        chk("grant_n", got.size(), exp_grants.size());
        for (int i = 0; i < got.size() && i < exp_grants.size(); i++)
            chk($sformatf("grant%0d", i), 32'(got[i]), exp_grants[i]);
        chk("assignment", assignment, ea);
        chk("free", free, ef);
        chk("imp_count", imp_count, n);
        chk("conflict", conflict, ec);
        m_ptr = np;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_outs", {unit_load, clause_enable, grant, assignment, free, imp_count, busy, done, conflict}, 0);
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        @(negedge clock);
    endtask

    task automatic cfg(input logic [U-1:0] en);
        u_en = en;
        for (int i = 0; i < U; i++) begin
            u_vec[i] = '0;
            u_mode[i] = 2'd0;
        end
        u_pol = '0;
    endtask

    initial begin
        cfg('0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_state", {unit_load, clause_enable, grant, assignment, free, imp_count, busy, done, conflict}, 0);
        reset = 1'b1;
        @(negedge clock);
        // no implications at all
        run_round(8'h00, 8'hFF, 0, 0);
        // single implication from unit 2
        cfg(4'b0100);
        u_vec[2] = 8'b0000_0100;
        u_pol = 4'b0100;
        run_round(8'h00, 8'hFF, 0, 0);
        // round-robin from ptr 0, wrapping back to 0
        do_reset();
        cfg(4'b1001);
        u_vec[0] = 8'h01;
        u_vec[3] = 8'h02;
        u_pol = 4'b1000;
        run_round(8'h00, 8'hFF, 0, 0);
        run_round(8'hFF, 8'hFF, 0, 0);
        // unit clause with no free literal
        cfg(4'b0010);
        u_vec[1] = 8'h01;
        u_mode[1] = 2'd1;
        run_round(8'h00, 8'hFE, 0, 0);
        // lowest free literal chosen, neighbour untouched
        cfg(4'b0001);
        u_vec[0] = 8'b0011_0000;
        u_mode[0] = 2'd2;
        run_round(8'hFF, 8'hFF, 0, 0);
        // abort during APPLY
        cfg(4'b0001);
        u_vec[0] = 8'h01;
        u_mode[0] = 2'd2;
        u_pol = 4'b0001;
        u_used = '0;
        init_assignment = 8'hA5;
        init_free = 8'hFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20 && grant == 0; i++) @(negedge clock);
        chk("abort_grant", grant != 0, 1);
        #2;
        do_reset();
        chk("abort_nodone", done, 0);
        run_round(8'h3C, 8'hFF, 1, 1);
        run_round(8'h00, 8'hFF, 1, 0);
        for (int r = 0; r < 40; r++) begin
            u_en = U'($urandom);
            u_pol = U'($urandom);
            for (int i = 0; i < U; i++) begin
                u_mode[i] = 2'($urandom_range(0, 2));
                u_vec[i] = (V'(1) << $urandom_range(0, V - 1)) | ($urandom_range(0, 1) ? V'(1) << $urandom_range(0, V - 1) : V'(0));
            end
            run_round(V'($urandom), V'($urandom) | 8'h11, 1'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcp_scheduler.md
Name: bcp_scheduler

Overview:
- Sequences one Boolean-constraint-propagation (BCP) round over an array of unit_num clause check units.
- Loads the initial assignment, pulses the check units to evaluate, and arbitrates round-robin among units reporting an implication.
- Applies one implication per iteration to the shared assignment/free vectors and re-evaluates.
- Stops when no implication remains (done) or when a unit clause has no free literal left (conflict).

Parameters:
- var_num, 8, number of variables (width of assignment/free/implication vectors)
- unit_num, 4, number of check units arbitrated
- size, 8, width of the implication counter

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  pulse: begin a BCP round; ignored while busy=1
- init_assignment  input  var_num  assignment values loaded at start
- init_free  input  var_num  1 = variable unassigned; loaded at start
- imp_valid  input  unit_num  per-unit implication_exist
- imp_vec  input  unit_num*var_num  per-unit implication vector; unit i occupies bits [i*var_num +: var_num]
- imp_pol  input  unit_num  per-unit polarity of the implied literal
- unit_load  output  1  one-cycle pulse: check units reload clause/counter
- clause_enable  output  1  one-cycle pulse: check units evaluate
- grant  output  unit_num  one-hot, the unit whose implication is being applied this cycle
- assignment  output  var_num  current assignment, drives the check units
- free  output  var_num  current free mask, drives the check units
- imp_count  output  size  implications applied this round; saturates at all-ones
- busy  output  1  high from the cycle after start until done/conflict
- done  output  1  one-cycle pulse at end of round
- conflict  output  1  set at end of round if a conflict ended it; held until next start

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0, including assignment, free, imp_count, grant and conflict.
  - Round-robin pointer = 0.
  - Reset mid-round aborts immediately; no done pulse.
- IDLE: on start=1, next state is LOAD.
  - assignment<=init_assignment, free<=init_free, imp_count<=0, conflict<=0, busy<=1.
- LOAD: unit_load=1 for this cycle only, then go to EVAL.
- EVAL: clause_enable=1 for this cycle only, then go to WAIT.
- WAIT: one cycle for the registered imp_valid/imp_vec outputs to settle, then go to ARB.
- ARB, candidate selection:
  - Candidate = first unit with imp_valid=1, searching indices ptr, ptr+1, ..., unit_num-1, 0, ..., ptr-1.
  - No candidate: go to DONE with conflict=0.
  - Candidate g with (imp_vec[g] & free)==0 (unit clause with no free literal): go to DONE with conflict<=1.
  - Otherwise go to APPLY with the target variable v = lowest set bit of (imp_vec[g] & free).
- APPLY:
  - grant=one-hot(g) for this cycle only.
  - assignment[v]<=imp_pol[g], free[v]<=0.
  - imp_count<=imp_count+1, saturating.
  - ptr<=(g+1) mod unit_num.
  - Next state is EVAL; LOAD is not repeated, because unit counters persist within a round.
- DONE: done=1 for one cycle, busy<=0, then go to IDLE.
  - assignment, free, imp_count and conflict hold until the next start.
- Latency:
  - start to first ARB: 4 cycles (IDLE→LOAD→EVAL→WAIT→ARB).
  - Each applied implication: 4 cycles (ARB→APPLY→EVAL→WAIT→ARB).
- Termination: every APPLY clears one free bit, so a round completes within var_num iterations.
- Simultaneous events:
  - start while busy is ignored.
  - A start in the same cycle as the DONE pulse is ignored.
  - A start in the cycle after DONE is accepted.
- imp_valid bits are sampled only in ARB; changes in other states have no effect.

Test Plan:
1. Reset, then start with init_free=8'hFF, init_assignment=0, imp_valid=0 throughout → unit_load at cycle 1, clause_enable at cycle 2, done at cycle 5; imp_count=0, conflict=0, free=8'hFF.
2. Start; in ARB, unit 2 imp_valid=1, imp_vec[2]=8'b0000_0100, imp_pol[2]=1; bench drops imp_valid after the grant → grant=4'b0100, assignment[2]=1, free=8'hFB, imp_count=1, done, conflict=0.
3. Units 0 and 3 valid at every ARB, each targeting a different free variable, ptr=0 → first grant=4'b0001, second grant=4'b1000; ptr wraps to 0 after unit 3 is granted.
4. Start with init_free=8'hFE; unit 1 valid with imp_vec[1]=8'h01 → no APPLY; done pulses with conflict=1; free=8'hFE, imp_count=0.
5. Unit 0 imp_vec=8'b0011_0000, free=8'hFF, imp_pol=0 → variable 4 assigned 0, free=8'hEF; variable 5 untouched.
6. Assert reset low during APPLY → all outputs 0 asynchronously, no done pulse; after release, a new start runs normally; a second start while busy is ignored.
